ecpri_resp_sched: RTL
=====================

Name: ecpri_resp_sched

Overview:
- Schedules eCPRI remote-memory-access responses between the eCPRI rx parser and the tx frame builder.
- Accepts single-cycle write-response and read-response requests, each carrying a payload length, and queues them in a small FIFO.
- Issues the queued requests to the tx builder one at a time using a start/done handshake, with a watchdog timeout and drop/error accounting.

Parameters:
- DATA_WIDTH, 8, width of the response payload length.
- QUEUE_DEPTH, 4, number of queue entries; must be a power of 2 and at least 2.
- QPTR_WIDTH, 2, log2(QUEUE_DEPTH).
- TIMEOUT_CYCLES, 255, maximum number of cycles to wait for tx_done after tx_start.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- wr_resp_req  input  1  one-cycle pulse: enqueue a write response.
- rd_resp_req  input  1  one-cycle pulse: enqueue a read response.
- req_len  input  DATA_WIDTH  payload length for a read response; ignored for a write response (its length is stored as 0).
- tx_start  output  1  one-cycle pulse: tx builder starts a response.
- tx_resp_type  output  1  0 = write response, 1 = read response; valid from tx_start until tx_done.
- tx_len  output  DATA_WIDTH  payload length; held alongside tx_resp_type.
- tx_done  input  1  one-cycle pulse from the tx builder: response sent.
- q_count  output  QPTR_WIDTH+1  current number of queued entries.
- q_full  output  1  high when q_count == QUEUE_DEPTH.
- drop_cnt  output  8  count of dropped requests; saturates at 255.
- timeout_err  output  1  sticky; set when a timeout occurs.
- wr_issued_cnt  output  16  number of write responses issued (see Optional Feature).
- rd_issued_cnt  output  16  number of read responses issued (see Optional Feature).

Behaviour:
- Reset values: every output is 0, the queue is empty, the FSM is in IDLE, and the timeout counter is 0. A reset asserted mid-handshake abandons the in-flight response without raising timeout_err.
- Queue storage: each entry is {type, len}. Pointers wrap modulo QUEUE_DEPTH. All outputs are registered.
- Enqueue: a request sampled at edge N is stored at edge N and is visible in q_count after edge N.
- Pop accounting: a pop occurring in the same cycle frees its slot for that cycle's enqueue. Free slots = QUEUE_DEPTH - q_count + pop.
- Simultaneous wr_resp_req and rd_resp_req:
  - The read entry is written first, then the write entry.
  - If only one slot is free, the read is kept, the write is dropped, and drop_cnt increments by 1.
  - If no slot is free, both are dropped and drop_cnt increments by 2, saturating at 255.
- Single request with no free slot: the request is dropped and drop_cnt increments by 1.
- FSM states: IDLE, ISSUE, WAIT_DONE, GAP.
- IDLE:
  - If q_count != 0, pop the head entry, latch tx_resp_type and tx_len, and go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - tx_start = 1 for exactly this one cycle.
  - Clear the timeout counter and go to WAIT_DONE.
- WAIT_DONE:
  - On tx_done, go to GAP.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT_CYCLES, set timeout_err and go to GAP.
  - tx_done outside WAIT_DONE is ignored.
- GAP: one idle cycle enforcing spacing between responses, then go to IDLE.
- Latency: a request accepted at edge N into an empty queue with the FSM in IDLE produces tx_start high during cycle N+1 to N+2. Minimum issue-to-issue spacing is 4 cycles when tx_done arrives on the first WAIT_DONE cycle.
- tx_resp_type and tx_len hold their last value after GAP; they change only on a pop.
- A zero-length read response is issued normally as a header-only response.

Optional Feature:
- Macro: ECPRI_RESP_STATS_EN.
- Defined: wr_issued_cnt and rd_issued_cnt increment on each tx_start of the matching type. Both wrap modulo 2^16 and reset to 0.
- Undefined: both ports are driven constant 0 and no counter registers are generated. Scheduling behaviour is identical in both cases.

Test Plan:
- Single read, req_len=0x20, tx_done 3 cycles after tx_start -> exactly one tx_start pulse with tx_resp_type=1 and tx_len=0x20; q_count returns to 0; drop_cnt=0.
- wr and rd requests in the same cycle into an empty queue -> two issues in order: read (type 1) first, then write (type 0, tx_len 0); spacing between tx_start pulses ≥ 4 cycles.
- tx_done held low, 6 requests -> first entry issued, queue holds 4; q_full=1; drop_cnt=1. After timeout_err is set, the remaining 4 issue with tx_done pulsed promptly.
- Queue full, and in the cycle of the pop (FSM in IDLE) a new request arrives -> the request is accepted; q_count stays 4; drop_cnt unchanged.
- Reset asserted during WAIT_DONE with 3 entries queued -> next cycle all outputs are 0 and q_count=0; no tx_start follows without new requests.
- With ECPRI_RESP_STATS_EN defined, 3 reads and 2 writes issued -> rd_issued_cnt=3 and wr_issued_cnt=2; without the macro, both read 0.

Source files
------------

// File: rtl/ecpri_resp_sched.sv
// ecpri_resp_sched: queues eCPRI write/read response requests and issues them
// one at a time to the tx frame builder over a start/done handshake, with a
// watchdog timeout and drop accounting.
// Optional macro ECPRI_RESP_STATS_EN: enables per-type issued-response counters.
module ecpri_resp_sched #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned QUEUE_DEPTH    = 4,
    parameter int unsigned QPTR_WIDTH     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_resp_req,
    input  logic                  rd_resp_req,
    input  logic [DATA_WIDTH-1:0] req_len,
    output logic                  tx_start,
    output logic                  tx_resp_type,
    output logic [DATA_WIDTH-1:0] tx_len,
    input  logic                  tx_done,
    output logic [QPTR_WIDTH:0]   q_count,
    output logic                  q_full,
    output logic [7:0]            drop_cnt,
    output logic                  timeout_err,
    output logic [15:0]           wr_issued_cnt,
    output logic [15:0]           rd_issued_cnt
);

    localparam int unsigned CNT_W = QPTR_WIDTH + 1;
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef struct packed {
        logic                  rtype;
        logic [DATA_WIDTH-1:0] len;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        GAP
    } state_t;

    entry_t                mem [QUEUE_DEPTH];
    logic [QPTR_WIDTH-1:0] wr_ptr;
    logic [QPTR_WIDTH-1:0] rd_ptr;
    state_t                state;
    logic [TMO_W-1:0]      tmo_cnt;

    logic                  pop_c;
    logic                  rd_acc_c;
    logic                  wr_acc_c;
    logic [CNT_W:0]        free_c;
    logic [1:0]            ndrop_c;
    logic [CNT_W-1:0]      next_count_c;
    logic [8:0]            drop_sum_c;
    entry_t                head_c;

    // Pop/accept decisions; a same-cycle pop frees a slot for the enqueue.
    always_comb begin
        head_c       = mem[rd_ptr];
        pop_c        = (state == IDLE) && (q_count != '0);
        free_c       = (CNT_W+1)'(QUEUE_DEPTH) - (CNT_W+1)'(q_count) + (CNT_W+1)'(pop_c);
        rd_acc_c     = rd_resp_req && (free_c != '0);
        wr_acc_c     = wr_resp_req &&
                       (rd_resp_req ? (free_c >= (CNT_W+1)'(2)) : (free_c != '0));
        ndrop_c      = 2'(rd_resp_req && !rd_acc_c) + 2'(wr_resp_req && !wr_acc_c);
        next_count_c = q_count - CNT_W'(pop_c) + CNT_W'(rd_acc_c) + CNT_W'(wr_acc_c);
        drop_sum_c   = 9'(drop_cnt) + 9'(ndrop_c);
    end

    // Entry storage: read entry lands first, write entry right behind it.
    always_ff @(posedge clk) begin
        if (rd_acc_c) begin
            mem[wr_ptr] <= {1'b1, req_len};
        end
        if (wr_acc_c) begin
            mem[wr_ptr + QPTR_WIDTH'(rd_acc_c)] <= {1'b0, DATA_WIDTH'(0)};
        end
    end

    // Queue pointers, occupancy and saturating drop counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            q_count  <= '0;
            q_full   <= 1'b0;
            drop_cnt <= '0;
        end else begin
            wr_ptr   <= wr_ptr + QPTR_WIDTH'(rd_acc_c) + QPTR_WIDTH'(wr_acc_c);
            rd_ptr   <= rd_ptr + QPTR_WIDTH'(pop_c);
            q_count  <= next_count_c;
            q_full   <= (next_count_c == CNT_W'(QUEUE_DEPTH));
            drop_cnt <= (drop_sum_c > 9'd255) ? 8'hFF : drop_sum_c[7:0];
        end
    end

    // Issue FSM: pop in IDLE, pulse start in ISSUE, wait for done or timeout, one gap cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            tx_start     <= 1'b0;
            tx_resp_type <= 1'b0;
            tx_len       <= '0;
            tmo_cnt      <= '0;
            timeout_err  <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop_c) begin
                        tx_resp_type <= head_c.rtype;
                        tx_len       <= head_c.len;
                        tx_start     <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    tmo_cnt <= '0;
                    state   <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (tx_done) begin
                        state <= GAP;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                        if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                            timeout_err <= 1'b1;
                            state       <= GAP;
                        end
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef ECPRI_RESP_STATS_EN
    // Per-type issue counters, stepping with the start pulse of each response.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_issued_cnt <= '0;
            rd_issued_cnt <= '0;
        end else if (pop_c) begin
            if (head_c.rtype) begin
                rd_issued_cnt <= rd_issued_cnt + 16'd1;
            end else begin
                wr_issued_cnt <= wr_issued_cnt + 16'd1;
            end
        end
    end
`else
    assign wr_issued_cnt = '0;
    assign rd_issued_cnt = '0;
`endif

endmodule
